// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and issues in-order requests to instruction memory.
// Returned words are buffered in a small queue that feeds the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4,
    parameter int          CNT_W    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        fetch_misalign
);

    localparam int               PTR_W      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(QDEPTH);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] q_head;
    logic [PTR_W-1:0] q_tail;
    logic [PTR_W-1:0] tag_head;
    logic [PTR_W-1:0] tag_tail;

    logic [31:0] q_instr  [QDEPTH];
    logic [31:0] q_pc     [QDEPTH];
    logic [31:0] tag_fifo [QDEPTH];

    logic             ack_seen;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;
    logic [CNT_W-1:0] out_after_ack;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit covers both in-flight requests and queued words, so every ack has a free slot.
    assign ack_seen      = imem_ack && (outstanding != '0);
    assign credit_used   = {1'b0, outstanding} + {1'b0, count};
    assign issue         = !reset && (state == RUN) && !redirect && !halt && (credit_used < CREDIT_MAX);
    assign out_after_ack = outstanding - CNT_W'(ack_seen);

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign dec_valid = (count != '0) && !halt;
    assign dec_instr = q_instr[q_head];
    assign dec_pc    = q_pc[q_head];

    assign pop  = dec_valid && dec_ready && !redirect;
    assign push = ack_seen && (state == RUN) && !redirect;

    // A redirect flushes everything; acks still owed by memory become discards drained in DRAIN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= RUN;
            fetch_pc       <= RESET_PC;
            outstanding    <= '0;
            discard        <= '0;
            count          <= '0;
            q_head         <= '0;
            q_tail         <= '0;
            tag_head       <= '0;
            tag_tail       <= '0;
            fetch_misalign <= 1'b0;
        end else if (redirect) begin
            fetch_pc       <= {redirect_pc[31:2], 2'b00};
            fetch_misalign <= |redirect_pc[1:0];
            count          <= '0;
            q_head         <= '0;
            q_tail         <= '0;
            tag_head       <= '0;
            tag_tail       <= '0;
            outstanding    <= out_after_ack;
            discard        <= out_after_ack;
            state          <= (out_after_ack != '0) ? DRAIN : RUN;
        end else begin
            fetch_misalign <= 1'b0;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                tag_tail <= next_ptr(tag_tail);
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(ack_seen);
            if (push) begin
                q_tail   <= next_ptr(q_tail);
                tag_head <= next_ptr(tag_head);
            end
            if (pop) begin
                q_head <= next_ptr(q_head);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if ((state == DRAIN) && ack_seen) begin
                discard <= discard - CNT_W'(1);
                if (discard == CNT_W'(1)) begin
                    state <= RUN;
                end
            end
        end
    end

    // Storage needs no reset: pointers and count decide which entries are meaningful.
    always_ff @(posedge clock) begin
        if (issue) begin
            tag_fifo[tag_tail] <= fetch_pc;
        end
        if (push) begin
            q_instr[q_tail] <= imem_rdata;
            q_pc[q_tail]    <= tag_fifo[tag_head];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model with a variable-latency memory,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        fetch_misalign;

    always #5 clock = ~clock;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .QDEPTH  (QDEPTH),
        .CNT_W   (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready),
        .fetch_misalign(fetch_misalign)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } flight_t;

    mem_req_t    mem_q[$];
    flight_t     m_flight[$];
    logic [31:0] m_queue[$];
    logic [31:0] m_pc;
    bit          m_mis;

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;

    bit          st_reset;
    bit          st_redirect;
    bit          st_halt;
    bit          st_ready;
    logic [31:0] st_rpc;
    int          lat_min = 1;
    int          lat_max = 1;

    logic        s_req;
    logic        s_dv;
    logic        s_mis;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // One clock per iteration: drive at negedge, sample and compare 1ns later, then advance the model.
    task automatic applyStimulus(input int n);
        bit          ack_now;
        bit          exp_req;
        bit          exp_dv;
        bit          do_pop;
        bit          draining;
        flight_t     f;
        logic [31:0] dummy;
        mem_req_t    md;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            reset       = st_reset;
            redirect    = st_redirect;
            redirect_pc = st_rpc;
            halt        = st_halt;
            dec_ready   = st_ready;
            ack_now     = !st_reset && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
            imem_ack    = ack_now;
            imem_rdata  = ack_now ? word_of(mem_q[0].addr) : $urandom();
            #1;
            s_req   = imem_req;
            s_addr  = imem_addr;
            s_dv    = dec_valid;
            s_pc    = dec_pc;
            s_instr = dec_instr;
            s_mis   = fetch_misalign;

            draining = (m_flight.size() > 0) && m_flight[0].stale;
            exp_req  = !st_reset && !draining && !st_redirect && !st_halt &&
                       ((m_flight.size() + m_queue.size()) < QDEPTH);
            exp_dv   = (m_queue.size() != 0) && !st_halt;

            if (st_reset) begin
                checkOutput("imem_req_in_reset", {31'd0, s_req}, 32'd0);
            end else begin
                checkOutput("imem_req", {31'd0, s_req}, {31'd0, exp_req});
                checkOutput("imem_addr", s_addr, m_pc);
                checkOutput("dec_valid", {31'd0, s_dv}, {31'd0, exp_dv});
                checkOutput("fetch_misalign", {31'd0, s_mis}, {31'd0, m_mis});
                if (exp_dv) begin
                    checkOutput("dec_pc", s_pc, m_queue[0]);
                    checkOutput("dec_instr", s_instr, word_of(m_queue[0]));
                end
            end

            if (st_reset) begin
                m_pc  = RESET_PC;
                m_mis = 1'b0;
                m_flight.delete();
                m_queue.delete();
                mem_q.delete();
            end else begin
                do_pop  = exp_dv && st_ready && !st_redirect;
                f.addr  = '0;
                f.stale = 1'b1;
                if (ack_now && (m_flight.size() > 0)) f = m_flight.pop_front();
                if (st_redirect) begin
                    m_queue.delete();
                    foreach (m_flight[i]) m_flight[i].stale = 1'b1;
                    m_pc  = {st_rpc[31:2], 2'b00};
                    m_mis = |st_rpc[1:0];
                end else begin
                    if (do_pop) dummy = m_queue.pop_front();
                    if (ack_now && !f.stale) m_queue.push_back(f.addr);
                    if (exp_req) begin
                        m_flight.push_back('{addr: m_pc, stale: 1'b0});
                        m_pc = m_pc + 32'd4;
                    end
                    m_mis = 1'b0;
                end
                if (ack_now) md = mem_q.pop_front();
                if (s_req === 1'b1) mem_q.push_back('{addr: s_addr, due: cyc + $urandom_range(lat_max, lat_min)});
            end
            cyc++;
        end
    endtask

    task automatic doReset();
        st_reset    = 1'b1;
        st_redirect = 1'b0;
        st_halt     = 1'b0;
        st_rpc      = '0;
        applyStimulus(2);
        st_reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          issued;
        bit          found;
        logic [31:0] wrap_exp [3];

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        dec_ready   = 1'b0;

        // Straight-line fetch with single-cycle memory.
        lat_min = 1; lat_max = 1; st_ready = 1'b1;
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            if (i < 3) checkOutput("t1_addr", s_addr, 32'(i * 4));
            checkOutput("t1_dec_valid", {31'd0, s_dv}, (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) checkOutput("t1_dec_pc", s_pc, 32'((i - 2) * 4));
        end

        // Decoder stalled: credit stops issue after QDEPTH requests.
        doReset();
        st_ready = 1'b0;
        issued   = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            if (s_req) issued++;
        end
        checkOutput("t2_issued", 32'(issued), 32'(QDEPTH));
        checkOutput("t2_req_off", {31'd0, s_req}, 32'd0);
        st_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("t2_dec_pc", s_pc, 32'(i * 4));
        end

        // Redirect with two requests in flight to a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        doReset();
        applyStimulus(2);
        st_redirect = 1'b1; st_rpc = 32'h100;
        applyStimulus(1);
        checkOutput("t3_req_redirect", {31'd0, s_req}, 32'd0);
        st_redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1);
            checkOutput("t3_drain_dv", {31'd0, s_dv}, 32'd0);
            checkOutput("t3_drain_req", {31'd0, s_req}, 32'd0);
        end
        applyStimulus(1);
        checkOutput("t3_req_new", {31'd0, s_req}, 32'd1);
        checkOutput("t3_addr_new", s_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            applyStimulus(1);
            if (s_dv) found = 1'b1;
        end
        checkOutput("t3_delivered", {31'd0, found}, 32'd1);
        if (found) checkOutput("t3_dec_pc", s_pc, 32'h100);

        // Halt with two queued and one outstanding.
        lat_min = 1; lat_max = 1;
        doReset();
        st_ready = 1'b0;
        applyStimulus(3);
        st_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("t4_halt_dv", {31'd0, s_dv}, 32'd0);
            checkOutput("t4_halt_req", {31'd0, s_req}, 32'd0);
        end
        st_halt = 1'b0; st_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("t4_dec_valid", {31'd0, s_dv}, 32'd1);
            checkOutput("t4_dec_pc", s_pc, 32'(i * 4));
        end

        // Redirect and halt together to a misaligned target.
        lat_min = 2; lat_max = 2;
        doReset();
        applyStimulus(4);
        st_redirect = 1'b1; st_halt = 1'b1; st_rpc = 32'h202;
        applyStimulus(1);
        st_redirect = 1'b0; st_halt = 1'b0;
        applyStimulus(1);
        checkOutput("t5_misalign", {31'd0, s_mis}, 32'd1);
        checkOutput("t5_addr", s_addr, 32'h200);
        checkOutput("t5_queue_empty", {31'd0, s_dv}, 32'd0);
        applyStimulus(1);
        checkOutput("t5_misalign_pulse", {31'd0, s_mis}, 32'd0);

        // PC wrap at the top of the address space, then reset mid-stream.
        lat_min = 1; lat_max = 1;
        doReset();
        st_redirect = 1'b1; st_rpc = 32'hFFFF_FFF8;
        applyStimulus(1);
        st_redirect = 1'b0;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("t6_wrap_req", {31'd0, s_req}, 32'd1);
            checkOutput("t6_wrap_addr", s_addr, wrap_exp[i]);
        end
        applyStimulus(3);
        st_reset = 1'b1;
        applyStimulus(1);
        st_reset = 1'b0;
        applyStimulus(1);
        checkOutput("t6_reset_addr", s_addr, RESET_PC);
        checkOutput("t6_reset_dv", {31'd0, s_dv}, 32'd0);

        // Randomized traffic against the model.
        lat_min = 1; lat_max = 4;
        doReset();
        for (int i = 0; i < 3000; i++) begin
            st_ready    = ($urandom_range(0, 3) != 0);
            st_halt     = ($urandom_range(0, 9) == 0);
            st_redirect = ($urandom_range(0, 19) == 0);
            st_rpc      = $urandom();
            st_reset    = ($urandom_range(0, 499) == 0);
            applyStimulus(1);
        end
        st_reset = 1'b0; st_redirect = 1'b0; st_halt = 1'b0;
        applyStimulus(5);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
